// File: rtl/mem_rsp_pkg.sv
// rtl/mem_rsp_pkg.sv - shared types and helpers for the memory responder
//
// Purpose: request opcode and FSM state encodings, plus the storage
//          address-width helper used by mem_responder and mem_responder_ram.
package mem_rsp_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Index width for a storage array of 'depth' words; never narrower than 1 bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// rtl/mem_responder_ram.sv - word storage with byte-enabled write and registered read
//
// Purpose: DEPTH x DATA_WIDTH storage cleared by reset.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears storage and rd_data)
//   wr_en            write this edge
//   wr_addr/wr_data  write word address / data
//   wr_be            per-byte write enables
//   rd_en            capture mem[rd_addr] into rd_data this edge
//   rd_addr          read word address
//   rd_data          registered read data, held until the next rd_en
module mem_responder_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding request/response memory with 1-cycle latency
//
// Purpose: accepts read/write requests, answers each one cycle after accept,
//          flags out-of-range addresses with rsp_err and leaves storage untouched.
// Config:  MEM_RESPONDER_WSTRB_EN adds req_wstrb byte enables for writes;
//          without it every write updates all bytes.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_op, req_addr, req_wdata      opcode, word address, write data
//   req_wstrb                        byte enables (MEM_RESPONDER_WSTRB_EN only)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               read data (0 for writes/errors), out-of-range flag
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  op_e                     req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef MEM_RESPONDER_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int RAW = addr_bits(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state, state_nxt;
  logic                  accept;
  logic                  in_range;
  logic                  wr_en, rd_en;
  logic [NB-1:0]         wr_be;
  logic                  rsp_rd_q;   // pending response carries RAM read data
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_L;
  assign wr_en    = accept && (req_op == OP_WRITE) && in_range;
  assign rd_en    = accept && (req_op == OP_READ) && in_range;

`ifdef MEM_RESPONDER_WSTRB_EN
  assign wr_be = req_wstrb;
`else
  assign wr_be = '1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: an accept in RESP implies rsp_ready, i.e. handshake plus reload.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = accept ? RESP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state == IDLE) || rsp_ready;
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && rsp_err_q;
    rsp_rdata = ((state == RESP) && rsp_rd_q) ? ram_rdata : '0;
  end

  // Response attributes are only reloaded on accept, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rd_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_rd_q  <= rd_en;
      rsp_err_q <= !in_range;
    end
  end

  mem_responder_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (RAW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (req_addr[RAW-1:0]),
    .wr_data (req_wdata),
    .wr_be   (wr_be),
    .rd_en   (rd_en),
    .rd_addr (req_addr[RAW-1:0]),
    .rd_data (ram_rdata)
  );

endmodule
